chol_dot_seq: RTL
=================

Name: chol_dot_seq

Overview:
Sequencer that drives the Cholesky MAC (subtract mode, P = C - A*B) as an initiator and accumulates a full dot-product update.
- Computes res = init - sum(a_i*b_i), i = 0..len-1, over a streamed operand sequence.
- Feeds each MAC result back as the next C operand.
- Sits between the Cholesky controller and the MAC for the off-diagonal update L(i,j) and diagonal pre-sqrt terms.

Parameters:
MAC_LATENCY, 4, MAC pipeline depth in cycles from sampled inputs to valid P; must match the MAC IP configuration.
LEN_W, 8, width of the term-count input (max 2^LEN_W - 1 terms).

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a dot-product update; honoured only in IDLE.
init  input  64  initial accumulator value (C of the first term); sampled with start.
len  input  LEN_W  number of (a,b) terms; sampled with start.
busy  output  1  high from the cycle after start is accepted until the cycle res_valid is asserted, inclusive.
op_valid  input  1  operand pair valid.
op_ready  output  1  sequencer can accept an operand pair.
op_a  input  32  multiplicand, signed two's complement.
op_b  input  32  multiplier, signed two's complement.
res_valid  output  1  one-cycle pulse; res_data valid.
res_data  output  64  final accumulator; held until the next res_valid.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State returns to IDLE; busy=0, op_ready=0, res_valid=0, res_data=0, accumulator=0, term counter=0.
  - MAC SCLR is driven from rst.
  - Reset mid-operation abandons the computation; no res_valid is issued.
- MAC control: CE held at 1 whenever not in reset.
  - Operand registers and the accumulator drive MAC A/B/C.
- Arithmetic: signed 32x32 product; 64-bit subtraction wraps modulo 2^64 with no saturation or overflow flag.
- States:
  - IDLE:
    - start=1 latches init into the accumulator, loads the term counter with len, sets busy.
    - len=0 -> DONE; else -> FETCH.
  - FETCH:
    - op_ready=1.
    - On op_valid&op_ready (cycle t): register op_a/op_b, decrement the counter, -> WAIT. op_ready drops at t+1.
  - WAIT:
    - MAC samples registered A/B/C at edge t+1.
    - A wait counter runs MAC_LATENCY cycles; P is latched into the accumulator at edge t+1+MAC_LATENCY.
    - Then -> FETCH if the counter is nonzero, else -> DONE.
    - Throughput: one term per MAC_LATENCY+2 cycles.
  - DONE:
    - res_valid=1 for exactly one cycle; res_data = accumulator; busy=0 on the following cycle; -> IDLE.
- Boundary conditions:
  - start while busy is ignored; inputs are not resampled.
  - op_valid in IDLE, WAIT or DONE: no handshake; the producer must hold the pair.
  - len=0: res_valid 2 cycles after start, with res_data=init.
  - len = max value: counter must not wrap; exactly 2^LEN_W - 1 terms are consumed.
  - Simultaneous start and res_valid cycle: start is ignored; start is accepted only from IDLE.
- Latency:
  - start -> res_valid = 2 + len*(MAC_LATENCY+2) cycles, with zero producer stall.
  - Producer stalls add cycle-for-cycle.

Decomposition:
- Shared package chol_pkg:
  - MAC_LATENCY default.
  - Operand width (32) and accumulator width (64) constants.
  - State enum {IDLE, FETCH, WAIT, DONE}.
- Sub-module: chol_mac, instantiated once. a/b/c come from the operand/accumulator registers; out goes to the accumulator; clken=1; rst=rst.
- The bench uses a behavioural MAC model of identical latency when the vendor IP is unavailable.

Test Plan:
- Single term: init=100, len=1, (3,4) -> res_data=88, res_valid at start+8 cycles (MAC_LATENCY=4).
- Three terms, signed: init=0, len=3, (-2,5),(7,-1),(-3,-3) -> 0+10+7-9 = 8; exactly 3 handshakes; op_ready low during WAIT.
- len=0: init=64'h8000_0000_0000_0000 -> res_data equals init, res_valid 2 cycles after start, no op_ready.
- Wrap and backpressure: init=0, len=2, (32'h8000_0000, 32'h8000_0000) twice with 3-cycle op_valid gaps -> res_data = 64'h8000_0000_0000_0000 (-2^63 modulo 2^64); latency extends by the stall cycles.
- Reset mid-operation: len=4, assert rst during the second WAIT -> no res_valid, busy=0; a new start (init=5, len=1, (1,1)) -> 4.
- start while busy: second start pulse with different init/len during FETCH -> ignored; result matches the first request only.

Source files
------------

// File: rtl/chol_pkg.sv
// Shared definitions for the Cholesky dot-product sequencer and its MAC.
package chol_pkg;

   localparam int MAC_LATENCY_DEF = 4;
   localparam int OP_W            = 32;
   localparam int ACC_W           = 64;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      DONE
   } seq_state_t;

   // Signed c - a*b; the 64x64 multiply keeps only the low 64 bits,
   // which is exactly the two's-complement product of the 32-bit operands.
   function automatic logic [ACC_W-1:0] mulSub(input logic [ACC_W-1:0] c,
                                               input logic [OP_W-1:0]  a,
                                               input logic [OP_W-1:0]  b);
      logic [ACC_W-1:0] aExt;
      logic [ACC_W-1:0] bExt;
      aExt = {{(ACC_W-OP_W){a[OP_W-1]}}, a};
      bExt = {{(ACC_W-OP_W){b[OP_W-1]}}, b};
      return c - (aExt * bExt);
   endfunction

endpackage

// File: rtl/chol_mac.sv
// Pipelined multiply-subtract P = C - A*B; P is valid LATENCY cycles after inputs are sampled.
module chol_mac
   import chol_pkg::*;
#(
   parameter int LATENCY = MAC_LATENCY_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clken,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic [ACC_W-1:0] c,
   output logic [ACC_W-1:0] p
);

   logic [ACC_W-1:0] pipe [LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe[i] <= '0;
         end
      end else if (clken) begin
         pipe[0] <= mulSub(c, a, b);
         for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign p = pipe[LATENCY-1];

endmodule

// File: rtl/chol_dot_seq.sv
// Dot-product update sequencer: res = init - sum(a_i*b_i), one MAC term at a time.
module chol_dot_seq
   import chol_pkg::*;
#(
   parameter int MAC_LATENCY = MAC_LATENCY_DEF,
   parameter int LEN_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ACC_W-1:0] init,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [OP_W-1:0]  op_a,
   input  logic [OP_W-1:0]  op_b,
   output logic             res_valid,
   output logic [ACC_W-1:0] res_data
);

   localparam int WAIT_W = $clog2(MAC_LATENCY + 1) + 1;

   seq_state_t       state;
   logic [LEN_W-1:0] termCnt;
   logic [WAIT_W-1:0] waitCnt;
   logic [OP_W-1:0]  opA;
   logic [OP_W-1:0]  opB;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] macP;

   chol_mac #(
      .LATENCY(MAC_LATENCY)
   ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .clken(1'b1),
      .a    (opA),
      .b    (opB),
      .c    (acc),
      .p    (macP)
   );

   // DONE spans two cycles so the res_valid cycle is never IDLE and a
   // coincident start is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         op_ready  <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         acc       <= '0;
         termCnt   <= '0;
         waitCnt   <= '0;
         opA       <= '0;
         opB       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc     <= init;
                  termCnt <= len;
                  busy    <= 1'b1;
                  if (len == '0) begin
                     state <= DONE;
                  end else begin
                     state    <= FETCH;
                     op_ready <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (op_valid && op_ready) begin
                  opA      <= op_a;
                  opB      <= op_b;
                  termCnt  <= termCnt - 1'b1;
                  op_ready <= 1'b0;
                  waitCnt  <= '0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (waitCnt == WAIT_W'(MAC_LATENCY)) begin
                  acc <= macP;
                  if (termCnt != '0) begin
                     state    <= FETCH;
                     op_ready <= 1'b1;
                  end else begin
                     state <= DONE;
                  end
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            DONE: begin
               if (!res_valid) begin
                  res_valid <= 1'b1;
                  res_data  <= acc;
               end else begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
